ram_arbiter: RTL

- Two-master arbiter and sequencer for the shared 256 x 64-bit single-port RAM in the factorial core.
- Master 0 is the factorial datapath; master 1 is the host/load port.
- Accepts at most one access per cycle, arbitrates between the masters, and drives the RAM cen/wen/s_addr/s_din registered.
- Returns read data to the issuing master, tagged with an rvalid strobe.
- Arbitration is round-robin with a bounded-hold rule, so a streaming master cannot starve the other.

---
 rtl/ram_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-master arbiter and sequencer for the shared single-port RAM of the
//   factorial core. Master 0 is the factorial datapath and master 1 is the
//   host/load port. At most one access is accepted per cycle. Arbitration is
//   round-robin with a bounded hold: one master keeps the RAM for at most
//   MAX_HOLD consecutive contended grants. The RAM strobes are registered,
//   and read data is routed back to the master that issued the read.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   mX_req/wr/addr/wdata         master X request (held until mX_gnt)
//   mX_gnt                       request accepted this cycle (combinational)
//   mX_rvalid/rdata              read return; rdata is 0 when rvalid is 0
//   cen, wen, s_addr, s_din      registered RAM strobes, address and data
//   s_dout                       RAM read data, valid two cycles after grant
module ram_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 64,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          cen,
  output logic          wen,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_din,
  input  logic [DW-1:0] s_dout
);

  localparam logic [3:0] HOLD = 4'(MAX_HOLD);

  // Arbitration state: last granted master (0/1) and its consecutive-grant count
  logic          r_last_gnt;
  logic [3:0]    r_streak;

  // Issue stage registers driving the RAM
  logic          r_cen;
  logic          r_wen;
  logic [AW-1:0] r_s_addr;
  logic [DW-1:0] r_s_din;
  logic          r_iss_own;

  // Read tag, aligned with s_dout
  logic          r_tag_vld;
  logic          r_tag_own;

  // Selected request
  logic          w_any;
  logic          w_sel;
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  // Grant decision depends only on req inputs and registered state, so there
  // is no path from s_dout into either gnt.
  always_comb begin
    w_any = m0_req | m1_req;
    if (m0_req && m1_req) begin
      // Stay with the previous owner until its streak reaches the hold limit
      w_sel = (r_streak < HOLD) ? r_last_gnt : ~r_last_gnt;
    end else begin
      w_sel = m1_req;
    end
    w_sel_wr    = w_sel ? m1_wr    : m0_wr;
    w_sel_addr  = w_sel ? m1_addr  : m0_addr;
    w_sel_wdata = w_sel ? m1_wdata : m0_wdata;
  end

  assign m0_gnt = w_any & ~w_sel;
  assign m1_gnt = w_any &  w_sel;

  // Arbitration state update; uncontended grants count toward the streak too
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_gnt <= 1'b1;
      r_streak   <= HOLD;
    end else if (w_any) begin
      if (w_sel == r_last_gnt) begin
        r_streak <= (r_streak >= HOLD) ? HOLD : r_streak + 4'd1;
      end else begin
        r_streak   <= 4'd1;
        r_last_gnt <= w_sel;
      end
    end
  end

  // Issue stage: grant in cycle N drives the RAM during cycle N+1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cen     <= 1'b0;
      r_wen     <= 1'b0;
      r_s_addr  <= '0;
      r_s_din   <= '0;
      r_iss_own <= 1'b0;
    end else begin
      r_cen <= w_any;
      r_wen <= w_any & w_sel_wr;
      if (w_any) begin
        r_s_addr  <= w_sel_addr;
        r_s_din   <= w_sel_wr ? w_sel_wdata : '0;
        r_iss_own <= w_sel;
      end
    end
  end

  // Tag stage: follows an issued read by one cycle, matching RAM read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_vld <= 1'b0;
      r_tag_own <= 1'b0;
    end else begin
      r_tag_vld <= r_cen & ~r_wen;
      r_tag_own <= r_iss_own;
    end
  end

  assign cen    = r_cen;
  assign wen    = r_wen;
  assign s_addr = r_s_addr;
  assign s_din  = r_s_din;

  assign m0_rvalid = r_tag_vld & ~r_tag_own;
  assign m1_rvalid = r_tag_vld &  r_tag_own;
  assign m0_rdata  = m0_rvalid ? s_dout : '0;
  assign m1_rdata  = m1_rvalid ? s_dout : '0;

endmodule
